// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code sequencer: prefix bytes,
// sequencer state encoding and the 10-bit key event layout {ext,brk,code}.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous show-ahead FIFO for key events; head is visible whenever
// non-empty and reads as zero when empty. A push while full is accepted
// only if a pop happens in the same cycle.
// Ports: CLK, RST (sync, active-high), i_push/i_data, i_pop,
//        o_data (head), o_full, o_empty.
module key_event_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Sequences PS/2 scan bytes through the E0/F0 prefix protocol into key
// events, buffered in a FIFO with valid/ready to the consumer.
// Ports: CLK, RST (sync, active-high); rx_valid/rx_code/rx_err from the
// receiver; ev_valid/ev_ready/ev_code/ev_ext/ev_break to the consumer;
// err_count (saturating), overflow (sticky).
// Build option: define KEY_REPEAT_FILTER_EN to drop typematic repeats.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_valid,
    input  logic [7:0] rx_code,
    input  logic       rx_err,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] err_count,
    output logic       overflow
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       r_state;
    ps2_state_t       w_state_n;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_n;
    logic [7:0]       r_err_cnt;
    logic             r_overflow;

    logic             w_cand;
    key_event_t       w_cand_ev;
    logic             w_push;
    logic             w_err;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [EVENT_W-1:0] w_head_raw;
    key_event_t       w_head;
    logic             w_is_ext;
    logic             w_is_brk;

    assign w_is_ext = (rx_code == PS2_EXT_PREFIX);
    assign w_is_brk = (rx_code == PS2_BRK_PREFIX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_n;
            r_tmo   <= w_tmo_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_tmo_n   = '0;
        w_cand    = 1'b0;
        w_cand_ev = '0;
        w_err     = 1'b0;
        if (rx_valid) begin
            if (rx_err) begin
                w_err     = 1'b1;
                w_state_n = ST_IDLE;
            end else begin
                w_cand_ev.code = rx_code;
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_is_ext) begin
                            w_state_n = ST_EXT;
                        end else if (w_is_brk) begin
                            w_state_n = ST_BRK;
                        end else begin
                            w_cand = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        w_state_n = ST_IDLE;
                        if (w_is_brk) begin
                            w_state_n = ST_EXT_BRK;
                        end else if (w_is_ext) begin
                            w_err = 1'b1;
                        end else begin
                            w_cand        = 1'b1;
                            w_cand_ev.ext = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        w_state_n = ST_IDLE;
                        if (w_is_ext || w_is_brk) begin
                            w_err = 1'b1;
                        end else begin
                            w_cand        = 1'b1;
                            w_cand_ev.brk = 1'b1;
                        end
                    end
                    ST_EXT_BRK: begin
                        w_state_n = ST_IDLE;
                        if (w_is_ext || w_is_brk) begin
                            w_err = 1'b1;
                        end else begin
                            w_cand        = 1'b1;
                            w_cand_ev.ext = 1'b1;
                            w_cand_ev.brk = 1'b1;
                        end
                    end
                    default: w_state_n = ST_IDLE;
                endcase
            end
        end else if (r_state != ST_IDLE) begin
            // A prefix with no follow-up byte is abandoned silently.
            if (r_tmo == TMO_LAST) begin
                w_state_n = ST_IDLE;
            end else begin
                w_tmo_n = r_tmo + 1'b1;
            end
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    logic       r_held_v;
    logic       r_held_ext;
    logic [7:0] r_held_code;
    logic       w_held_hit;
    logic       w_repeat;

    assign w_held_hit = r_held_v && (r_held_ext == w_cand_ev.ext)
                        && (r_held_code == w_cand_ev.code);
    assign w_repeat   = w_cand && !w_cand_ev.brk && w_held_hit;
    assign w_push     = w_cand && !w_repeat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_held_v    <= 1'b0;
            r_held_ext  <= 1'b0;
            r_held_code <= '0;
        end else if (w_cand) begin
            if (!w_cand_ev.brk && !w_held_hit) begin
                r_held_v    <= 1'b1;
                r_held_ext  <= w_cand_ev.ext;
                r_held_code <= w_cand_ev.code;
            end else if (w_cand_ev.brk && w_held_hit) begin
                r_held_v <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_cand;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_pop = !w_empty && ev_ready;

    key_event_fifo #(
        .W     (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_data  (w_cand_ev),
        .i_pop   (w_pop),
        .o_data  (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head    = key_event_t'(w_head_raw);
    assign ev_valid  = !w_empty;
    assign ev_code   = w_head.code;
    assign ev_ext    = w_head.ext;
    assign ev_break  = w_head.brk;
    assign err_count = r_err_cnt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Self-checking bench for ps2_scan_sequencer: directed protocol scenarios
// then randomized byte streams, checked every cycle against a queue model.
module tb_ps2_scan_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx_valid;
    logic [7:0] rx_code;
    logic       rx_err;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [7:0] err_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: pending prefixes as flags, events as a queue.
    logic [9:0] mq[$];
    bit         m_in_seq;
    bit         m_ext;
    bit         m_brk;
    int         m_idle;
    int         m_err;
    bit         m_ovf;
    bit         m_hv;
    bit         m_hext;
    logic [7:0] m_hcode;

    always #5 CLK = ~CLK;

    ps2_scan_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_valid  (rx_valid),
        .rx_code   (rx_code),
        .rx_err    (rx_err),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .err_count (err_count),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear_seq();
        m_in_seq = 0;
        m_ext    = 0;
        m_brk    = 0;
    endfunction

    function automatic void m_error();
        if (m_err < 255) m_err++;
        m_clear_seq();
    endfunction

    function automatic void m_emit(input bit ext, input bit brk,
                                   input logic [7:0] code);
`ifdef KEY_REPEAT_FILTER_EN
        bit hit;
        hit = m_hv && (m_hext == ext) && (m_hcode == code);
        if (!brk && hit) return;
        if (!brk) begin
            m_hv    = 1;
            m_hext  = ext;
            m_hcode = code;
        end else if (hit) begin
            m_hv = 0;
        end
`endif
        if (mq.size() < DEPTH) mq.push_back({ext, brk, code});
        else m_ovf = 1;
    endfunction

    function automatic void m_edge(input bit rst, input bit v,
                                   input logic [7:0] code, input bit err,
                                   input bit rdy);
        if (rst) begin
            mq.delete();
            m_clear_seq();
            m_idle = 0;
            m_err  = 0;
            m_ovf  = 0;
            m_hv   = 0;
            return;
        end
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (v) begin
            m_idle = 0;
            if (err) begin
                m_error();
            end else if (code == 8'hE0) begin
                if (m_in_seq) m_error();
                else begin
                    m_in_seq = 1;
                    m_ext    = 1;
                end
            end else if (code == 8'hF0) begin
                if (m_in_seq && (m_brk || !m_ext)) m_error();
                else begin
                    m_in_seq = 1;
                    m_brk    = 1;
                end
            end else begin
                m_emit(m_ext, m_brk, code);
                m_clear_seq();
            end
        end else if (m_in_seq) begin
            m_idle++;
            if (m_idle >= TMO) m_clear_seq();
        end
    endfunction

    task automatic step(input bit rst, input bit v, input logic [7:0] code,
                        input bit err, input bit rdy);
        logic [9:0] head;
        RST      = rst;
        rx_valid = v;
        rx_code  = code;
        rx_err   = err;
        ev_ready = rdy;
        @(posedge CLK);
        m_edge(rst, v, code, err, rdy);
        #1;
        head = (mq.size() > 0) ? mq[0] : 10'd0;
        chk("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
        chk("ev_code", 32'(ev_code), 32'(head[7:0]));
        chk("ev_ext", 32'(ev_ext), 32'(head[9]));
        chk("ev_break", 32'(ev_break), 32'(head[8]));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic send(input logic [7:0] code, input bit err, input bit rdy);
        step(0, 1, code, err, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, rdy);
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
    endtask

    initial begin
        RST      = 1'b1;
        rx_valid = 1'b0;
        rx_code  = 8'h00;
        rx_err   = 1'b0;
        ev_ready = 1'b0;

        do_reset();
        chk("reset_valid", 32'(ev_valid), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);

        // single make, consumer ready
        send(8'h1C, 0, 1);
        chk("t1_code", 32'(ev_code), 32'h1C);
        idle(2, 1);

        // break, then extended break
        send(8'hF0, 0, 1);
        send(8'h1C, 0, 1);
        send(8'hE0, 0, 1);
        send(8'hF0, 0, 1);
        send(8'h75, 0, 1);
        chk("t2_ext", 32'(ev_ext), 32'd1);
        idle(3, 1);

        // frame error mid-sequence, then E0 E0 protocol error
        send(8'hF0, 0, 1);
        send(8'h1C, 1, 1);
        send(8'h1C, 0, 1);
        send(8'hE0, 0, 1);
        send(8'hE0, 0, 1);
        chk("t3_err", 32'(err_count), 32'd2);
        idle(3, 1);

        // overflow with consumer stalled, then drain
        do_reset();
        for (int i = 1; i <= 9; i++) send(8'(i), 0, 0);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_head", 32'(ev_code), 32'h01);
        send(8'h2A, 0, 1);
        idle(10, 1);

        // timeout discards stale prefix; short gap keeps it
        do_reset();
        send(8'hE0, 0, 1);
        idle(20, 1);
        send(8'h1C, 0, 1);
        chk("t5_noext", 32'(ev_ext), 32'd0);
        idle(2, 1);
        send(8'hE0, 0, 1);
        idle(10, 1);
        send(8'h1C, 0, 1);
        chk("t5_ext", 32'(ev_ext), 32'd1);
        idle(2, 1);
        send(8'hF0, 0, 1);
        do_reset();
        send(8'h1C, 0, 1);
        chk("t5_rst_brk", 32'(ev_break), 32'd0);
        idle(2, 1);

        // typematic repeat stream
        send(8'h1C, 0, 0);
        send(8'h1C, 0, 0);
        send(8'h1C, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h1C, 0, 0);
        send(8'h1C, 0, 0);
        idle(8, 1);

        // randomized streams
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int sel;
            logic [7:0] c;
            bit rdy;
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                step(1, 0, 8'h00, 0, rdy);
            end else if ($urandom_range(0, 99) == 0) begin
                idle(25, rdy);
            end else if ($urandom_range(0, 1) == 0) begin
                idle($urandom_range(1, 3), rdy);
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 2) c = 8'hE0;
                else if (sel < 4) c = 8'hF0;
                else c = 8'($urandom_range(16'h10, 16'h14));
                send(c, ($urandom_range(0, 11) == 0), rdy);
            end
        end
        idle(12, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
